multiple_modules: RTL and testbench
===================================

MULTIPLE_MODULES -- requirements
Module: multiple_modules

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bit width of a, b, c, y; all logic operates bitwise.
REQ-002 SHALL have parameter CNT_W, default 8: width of rise_cnt.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port a, input, WIDTH: operand A.
REQ-006 SHALL have port b, input, WIDTH: operand B.
REQ-007 SHALL have port c, input, WIDTH: operand C.
REQ-008 SHALL have port y, output, WIDTH: registered result (a AND b) OR c.
REQ-009 SHALL have port y_comb, output, WIDTH: unregistered result (a AND b) OR c.
REQ-010 SHALL have port rise_cnt, output, CNT_W: count of 0->1 transitions of y bit 0.

Function
REQ-011 SHALL compute the AND term (a & b) in a separate submodule instance, sub_module1.
REQ-012 SHALL compute the OR of the AND term with c in a separate submodule instance, sub_module2.
REQ-013 SHALL drive y_comb = (a & b) | c combinationally, with zero cycle latency.
REQ-014 SHALL load y from y_comb on each rising clk edge, giving 1-cycle latency.
REQ-015 SHALL keep y free of combinational paths from a, b, c.
REQ-016 SHALL truth table per bit: a=1,b=1 -> 1; c=1 -> 1; all other combinations -> 0.
REQ-017 SHALL increment rise_cnt by 1 on a clock edge where y[0] is 0 and the new y[0] is 1.
REQ-018 SHALL saturate rise_cnt at 2^CNT_W-1; further rising transitions do not change it.
REQ-019 SHALL not change rise_cnt on 1->0 transitions or when y[0] is stable.
REQ-020 SHALL let input changes between clock edges affect only y_comb; y reflects the value sampled at the edge.

Reset
REQ-021 SHALL force y to 0 and rise_cnt to 0 immediately while reset_n is 0, independent of clk.
REQ-022 SHALL keep y_comb functional during reset, since it is combinational.
REQ-023 SHALL resume normal operation on the first rising clk edge after reset_n goes high; that edge may register a rising transition, and rise_cnt counts it.
REQ-024 SHALL, if reset_n asserts mid-operation, clear y and rise_cnt at once, with no pending update surviving.

Verification
REQ-025 SHALL cover truth table: drive all 8 (a,b,c) combinations with WIDTH=1 -> y_comb immediately, and y one edge later, equal 0,1,0,1,0,1,1,1 for abc=000..111.
REQ-026 SHALL cover latency: a=1,b=1,c=0 applied just after an edge -> y_comb=1 at once; y=0 until the next edge, then y=1.
REQ-027 SHALL cover the counter: toggle c 0->1->0 five times with a=b=0, one edge per phase -> rise_cnt=5.
REQ-028 SHALL cover saturation: CNT_W=2, produce 6 rising transitions on y[0] -> rise_cnt stops at 3.
REQ-029 SHALL cover async reset: with y=1 and rise_cnt=4, drop reset_n between edges -> y=0 and rise_cnt=0 before the next edge; y_comb stays 1.
REQ-030 SHALL cover free-running stimulus: a toggles every 10 ns, b every 55 ns, c every 75 ns for 300 ns -> y matches (a&b)|c sampled at each edge throughout.

Source files
------------

// File: rtl/multiple_modules.sv
// multiple_modules: bitwise (a & b) | c, built from two submodule instances.
//   clk       : single clock, all state updates on the rising edge
//   reset_n   : asynchronous, active-low reset for y and rise_cnt
//   a, b, c   : WIDTH-bit operands
//   y_comb    : unregistered (a & b) | c
//   y         : y_comb registered on each rising clk edge
//   rise_cnt  : saturating count of 0->1 transitions of y[0]

module sub_module1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

module sub_module2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] and_t,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);
  assign y = and_t | c;
endmodule

module multiple_modules #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_comb,
  output logic [CNT_W-1:0] rise_cnt
);
  logic [WIDTH-1:0] and_t;

  sub_module1 #(.WIDTH(WIDTH)) u_sub_module1 (
    .a (a),
    .b (b),
    .y (and_t)
  );

  sub_module2 #(.WIDTH(WIDTH)) u_sub_module2 (
    .and_t (and_t),
    .c     (c),
    .y     (y_comb)
  );

  // A rise is detected by comparing the current y[0] with the value about
  // to be loaded, so the count advances on the same edge y[0] goes high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y        <= '0;
      rise_cnt <= '0;
    end else begin
      y <= y_comb;
      if (!y[0] && y_comb[0] && (rise_cnt != '1))
        rise_cnt <= rise_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_multiple_modules.sv
// Testbench for multiple_modules: two instances (WIDTH=1/CNT_W=8 and
// WIDTH=4/CNT_W=2) checked every cycle against a behavioural model, plus
// directed literal checks for truth table, latency, counting, saturation,
// async reset and free-running stimulus.

module tb_multiple_modules;
  logic       clk;
  logic       reset_n;
  logic       a0, b0, c0;
  logic       y0, yc0;
  logic [7:0] cnt0;
  logic [3:0] a1, b1, c1;
  logic [3:0] y1, yc1;
  logic [1:0] cnt1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Behavioural model: expected registered value and unbounded rise tally.
  logic       m_y0 = 1'b0;
  logic [3:0] m_y1 = 4'h0;
  int         rises0 = 0;
  int         rises1 = 0;

  multiple_modules dut0 (
    .clk(clk), .reset_n(reset_n), .a(a0), .b(b0), .c(c0),
    .y(y0), .y_comb(yc0), .rise_cnt(cnt0)
  );

  multiple_modules #(.WIDTH(4), .CNT_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .a(a1), .b(b1), .c(c1),
    .y(y1), .y_comb(yc1), .rise_cnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // Model update: sample inputs at the edge, count 0->1 of bit 0.
  always @(posedge clk) begin
    logic       n0;
    logic [3:0] n1;
    if (reset_n) begin
      n0 = (a0 & b0) | c0;
      n1 = (a1 & b1) | c1;
      if (!m_y0 && n0) rises0++;
      if (!m_y1[0] && n1[0]) rises1++;
      m_y0 = n0;
      m_y1 = n1;
    end
  end

  always @(negedge reset_n) begin
    m_y0   = 1'b0;
    m_y1   = 4'h0;
    rises0 = 0;
    rises1 = 0;
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("y0", y0, m_y0);
      check("cnt0", cnt0, sat(rises0, 255));
      check("ycomb0", yc0, (a0 & b0) | c0);
      check("y1", y1, m_y1);
      check("cnt1", cnt1, sat(rises1, 3));
      check("ycomb1", yc1, (a1 & b1) | c1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    a0 = 0; b0 = 0; c0 = 0;
    a1 = '0; b1 = '0; c1 = '0;
    #1;
    reset_n = 1'b1;
  endtask

  logic [7:0] tt;

  initial begin
    tt = 8'hEA;  // expected output for abc = 7..0
    reset_n = 1'b0;
    a0 = 0; b0 = 0; c0 = 0;
    a1 = '0; b1 = '0; c1 = '0;

    // Reset state, y_comb live during reset
    #3;
    c0 = 1'b1;
    #1;
    check("rst_ycomb", yc0, 1'b1);
    check("rst_y", y0, 1'b0);
    check("rst_cnt", cnt0, 8'd0);
    @(posedge clk);
    #1;
    check("rst_y_after_edge", y0, 1'b0);
    check("rst_cnt_after_edge", cnt0, 8'd0);
    #1;
    c0 = 1'b0;
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Truth table: y_comb at once, y one edge later
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = i[2:0];
      {a0, b0, c0} = abc;
      #1;
      check("tt_ycomb", yc0, tt[i]);
      @(posedge clk);
      #1;
      check("tt_y", y0, tt[i]);
      #1;
    end

    // Latency
    a0 = 0; b0 = 0; c0 = 0;
    step();
    a0 = 1; b0 = 1;
    #1;
    check("lat_ycomb", yc0, 1'b1);
    check("lat_y_before", y0, 1'b0);
    @(posedge clk);
    #1;
    check("lat_y_after", y0, 1'b1);
    #1;

    // Counter and saturation
    pulse_reset();
    step();
    for (int k = 1; k <= 6; k++) begin
      c0 = 1'b1; c1 = 4'b0001;
      step();
      c0 = 1'b0; c1 = 4'b0000;
      step();
      if (k == 5) begin
        check("cnt_five", cnt0, 8'd5);
        check("sat_at5", cnt1, 2'd3);
      end
    end
    check("cnt_six", cnt0, 8'd6);
    check("sat_at6", cnt1, 2'd3);

    // Async reset mid-operation with y=1, rise_cnt=4
    pulse_reset();
    step();
    for (int k = 0; k < 4; k++) begin
      c0 = 1'b1;
      step();
      if (k != 3) begin
        c0 = 1'b0;
        step();
      end
    end
    check("pre_rst_y", y0, 1'b1);
    check("pre_rst_cnt", cnt0, 8'd4);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_y", y0, 1'b0);
    check("async_cnt", cnt0, 8'd0);
    check("async_ycomb", yc0, 1'b1);
    #2;
    reset_n = 1'b1;
    step();

    // Free-running stimulus for 300 ns
    a0 = 0; b0 = 0; c0 = 0;
    step();
    fork
      begin repeat (30) #10 a0 = ~a0; end
      begin repeat (5)  #55 b0 = ~b0; end
      begin repeat (4)  #75 c0 = ~c0; end
    join
    step();

    // Randomized phase with occasional mid-cycle resets
    repeat (300) begin
      {a0, b0, c0} = 3'($urandom);
      a1 = 4'($urandom);
      b1 = 4'($urandom);
      c1 = 4'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #1;
        reset_n = 1'b0;
        #5;
        reset_n = 1'b1;
      end
      step();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
